div_32_seq: RTL and testbench

- Sequential signed 32-bit divider for the ALU DIV operation, built on a non-restoring algorithm.
- Sits beside the add_32 adder in the ALU datapath. It feeds an add/subtract stage one partial remainder per cycle and consumes the sum.
- Results go to the HI/LO result registers: quotient to LO, remainder to HI.
- Handshake: start/busy/done, so the control unit stalls until done.

---
 rtl/div_32_seq_pkg.sv | 14 +
 rtl/div_32_seq_if.sv | 25 ++
 rtl/div_addsub_33.sv | 19 +
 rtl/div_32_seq.sv | 120 ++++++++++++
 tb/tb_div_32_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/div_32_seq_pkg.sv
// rtl/div_32_seq_pkg.sv - shared ALU divider constants and state encoding
package div_32_seq_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;
endpackage

// File: rtl/div_32_seq_if.sv
// rtl/div_32_seq_if.sv - start/busy/done handshake and operand/result bus for the divider
interface div_32_seq_if
  import div_32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_addsub_33.sv
// rtl/div_addsub_33.sv - partial-remainder add/subtract, direction chosen by the sign of A
module div_addsub_33
  import div_32_seq_pkg::*;
#(
  parameter int W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic         a_neg,
  output logic [W-1:0] sum
);
  logic [W-1:0] m_op;
  logic         cin;

  // Non-negative A subtracts: add the inverted operand with carry-in 1.
  assign m_op = a_neg ? m : ~m;
  assign cin  = ~a_neg;
  assign sum  = a + m_op + {{(W-1){1'b0}}, cin};
endmodule

// File: rtl/div_32_seq.sv
// rtl/div_32_seq.sv - sequential signed non-restoring divider, quotient to LO and remainder to HI
module div_32_seq
  import div_32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clock,
  input  logic            clear,
  div_32_seq_if.slave     bus
);
  div_state_t       state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   op_a;
  logic             op_neg;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_fix;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  // FIX reuses the same adder: forcing the "negative" select makes it A + M.
  assign op_a    = (state == FIX) ? a_reg : a_shift;
  assign op_neg  = (state == FIX) ? 1'b1 : a_reg[WIDTH];

  div_addsub_33 #(.W(WIDTH + 1)) u_addsub (
    .a     (op_a),
    .m     ({1'b0, m_reg}),
    .a_neg (op_neg),
    .sum   (sum)
  );

  assign a_fix   = a_reg[WIDTH] ? sum : a_reg;
  assign r_mag   = a_fix[WIDTH-1:0];
  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      a_reg  <= '0;
      q_reg  <= '0;
      m_reg  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quot_r <= DIV_ZERO_QUOTIENT;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              q_reg  <= dvd_mag;
              m_reg  <= dvs_mag;
              neg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              neg_r  <= bus.dividend[WIDTH-1];
              a_reg  <= '0;
              cnt    <= CNT_W'(WIDTH);
              dbz_r  <= 1'b0;
              busy_r <= 1'b1;
              state  <= ITER;
            end
          end
        end
        ITER: begin
          a_reg <= sum;
          q_reg <= {q_reg[WIDTH-2:0], ~sum[WIDTH]};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          a_reg  <= a_fix;
          quot_r <= neg_q ? -q_reg : q_reg;
          rem_r  <= neg_r ? -r_mag : r_mag;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_32_seq.sv
// tb/tb_div_32_seq.sv - randomized and directed self-checking bench for div_32_seq
module tb_div_32_seq;
  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   k_start = 0;

  div_32_seq_if #(.WIDTH(32)) bus ();

  div_32_seq dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: truncating signed division, with the overflow and zero-divisor rules.
  function automatic void calc(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  logic        armed = 1'b0;
  logic        m_busy, m_done, e_z;
  logic [31:0] e_q, e_r, p_q, p_r;
  int          m_left;

  // Cycle-level behavioural model: 34 cycles from start to done, 1 for a zero divisor.
  always @(posedge clk) begin
    if (clear) begin
      armed = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      e_q = 32'd0; e_r = 32'd0; e_z = 1'b0;
    end else if (armed) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; e_q = p_q; e_r = p_r; e_z = 1'b0;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (bus.start) begin
        calc(bus.dividend, bus.divisor, p_q, p_r);
        if (bus.divisor == 32'd0) begin
          m_done = 1'b1; e_q = p_q; e_r = p_r; e_z = 1'b1;
        end else begin
          m_busy = 1'b1; m_left = 33; e_z = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      if (!m_busy) begin
        check("quotient", bus.quotient, e_q);
        check("remainder", bus.remainder, e_r);
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e_z});
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1 bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k_start = cyc;
  endtask

  task automatic wait_done(output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        lat = cyc - k_start + 1;
        return;
      end
    end
  endtask

  task automatic expect_div(input string nm, input logic [31:0] xq, input logic [31:0] xr,
                            input logic xz, input int xlat);
    bit ok;
    int lat;
    wait_done(ok, lat);
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL %s: done never seen, required within 60 cycles", nm);
    end else begin
      check({nm, " latency"}, lat, xlat);
      check({nm, " q"}, bus.quotient, xq);
      check({nm, " r"}, bus.remainder, xr);
      check({nm, " dbz"}, {31'd0, bus.div_by_zero}, {31'd0, xz});
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int lat;
    int seen;
    logic [31:0] ra, rb;
    clear = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset q", bus.quotient, 32'd0);

    launch(32'd100, 32'd7);
    @(negedge clk);
    check("100/7 busy", {31'd0, bus.busy}, 32'd1);
    expect_div("100/7", 32'd14, 32'd2, 1'b0, 34);
    launch(-32'sd100, 32'd7);
    expect_div("-100/7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    launch(32'd100, -32'sd7);
    expect_div("100/-7", 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    launch(32'd5, 32'd0);
    expect_div("5/0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    launch(32'd9, 32'd3);
    expect_div("9/3", 32'd3, 32'd0, 1'b0, 34);
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    expect_div("min/-1", 32'h8000_0000, 32'd0, 1'b0, 34);
    launch(32'h7FFF_FFFF, 32'd1);
    expect_div("max/1", 32'h7FFF_FFFF, 32'd0, 1'b0, 34);

    launch(32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    #1 bus.start = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    expect_div("ignored start", 32'd100, 32'd0, 1'b0, 34);

    launch(32'd1000, 32'd10);
    repeat (19) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clear busy", {31'd0, bus.busy}, 32'd0);
    check("clear done", {31'd0, bus.done}, 32'd0);
    check("clear q", bus.quotient, 32'd0);
    check("clear r", bus.remainder, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("no done after clear", seen, 32'd0);
    launch(32'd7, 32'd2);
    expect_div("7/2", 32'd3, 32'd1, 1'b0, 34);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2, 3: rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      launch(ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        #1 bus.start = 1'b1; bus.dividend = $urandom; bus.divisor = $urandom;
      end
      wait_done(ok, lat);
      bus.start = 1'b0;
      if (!ok) begin
        n_vec++; n_bad++;
        $display("FAIL random %0d: done never seen for %h / %h", n, ra, rb);
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
